// File: rtl/nanov_serial_alu_if.sv
// nanov_serial_alu_if -- request/response bundle for the bit-serial ALU.
//   start/op/a/b : request, driven by the master and sampled by the ALU when idle
//   busy/done/d  : status and result, driven by the ALU
// Modports: master (requester side), slave (ALU side).
interface nanov_serial_alu_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [3:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] d;

   modport master (output start, op, a, b, input  busy, done, d);
   modport slave  (input  start, op, a, b, output busy, done, d);
endinterface

// File: rtl/nanov_serial_alu.sv
// nanov_serial_alu -- bit-serial 32-bit integer ALU for the nanoV RV32E core.
// One operand bit per clock, LSB first, through a 1-bit add/logic cell with a
// registered carry. 32 processing cycles per operation; d updates with a
// one-cycle done pulse.
// Ports:
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : slave side of nanov_serial_alu_if (start/op/a/b in, busy/done/d out)
// op[2:0] = RISC-V funct3, op[3] = instr bit 30 (SUB select).
// Build option: define NANOV_ALU_CMP_EN to enable SLT/SLTU; otherwise ops
// 010/011 return 0 with unchanged timing.
module nanov_serial_alu #(
   parameter int XLEN = 32
) (
   input  logic             clk,
   input  logic             rstn,
   nanov_serial_alu_if.slave bus
);
   localparam int            CW   = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic            cy_q;
   logic [3:0]      op_q;
   logic [XLEN-1:0] a_sr, b_sr;
   logic [XLEN-2:0] res_sr;   // bits already produced, newest at the top
   logic [XLEN-1:0] d_q;
   logic            done_q;

   logic accept, step, last, busy_c;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (bus.start)     state_nxt = S_RUN;
         S_RUN:  if (cnt == LAST)   state_nxt = S_IDLE;
         default:                   state_nxt = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy_c = (state == S_RUN);
      accept = (state == S_IDLE) && bus.start;
      step   = (state == S_RUN);
      last   = step && (cnt == LAST);
   end

   // ---------------- 1-bit cell ----------------
   logic            binv, ak, bk, bki, s, cout, rbit;
   logic [XLEN-1:0] res_nxt, fin;

   always_comb begin
      binv    = op_q[1] | op_q[3];
      ak      = a_sr[0];
      bk      = b_sr[0];
      bki     = bk ^ binv;
      s       = ak ^ bki ^ cy_q;
      cout    = (ak & bki) | (ak & cy_q) | (bki & cy_q);
      case (op_q[2:0])
         3'b000:  rbit = s;
         3'b100:  rbit = ak ^ bk;
         3'b110:  rbit = ak | bk;
         3'b111:  rbit = ak & bk;
         default: rbit = 1'b0;   // compares resolve at bit 31; shifts live elsewhere
      endcase
      res_nxt = {rbit, res_sr};
      fin     = res_nxt;
`ifdef NANOV_ALU_CMP_EN
      // On the last bit the signed/unsigned less-than replaces the whole word.
      // Operand signs differ -> A negative decides; else the sign of A-B does.
      if (op_q[2:1] == 2'b01)
         fin = {{(XLEN-1){1'b0}}, op_q[0] ? ~cout : ((ak != bk) ? ak : s)};
`endif
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt    <= '0;
         cy_q   <= 1'b0;
         op_q   <= '0;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         d_q    <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            op_q <= bus.op;
            a_sr <= bus.a;
            b_sr <= bus.b;
            cnt  <= '0;
            cy_q <= bus.op[1] | bus.op[3];   // carry-in of 1 completes the two's complement
         end else if (step) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            cy_q   <= cout;
            cnt    <= cnt + 1'b1;
            res_sr <= res_nxt[XLEN-1:1];
            if (last) begin
               d_q    <= fin;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign bus.busy = busy_c;
   assign bus.done = done_q;
   assign bus.d    = d_q;
endmodule

// File: tb/tb_nanov_serial_alu.sv
module tb_nanov_serial_alu;
   logic clk = 1'b0;
   logic rstn;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [31:0] last_d;

   nanov_serial_alu_if #(.XLEN(32)) bus ();
   nanov_serial_alu #(.XLEN(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));

   always #5 clk = ~clk;

   // Reference: plain 32-bit arithmetic on the whole words.
   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op[2:0])
         3'b000:  return op[3] ? a - b : a + b;
         3'b100:  return a ^ b;
         3'b110:  return a | b;
         3'b111:  return a & b;
`ifdef NANOV_ALU_CMP_EN
         3'b010:  return {31'd0, $signed(a) < $signed(b)};
         3'b011:  return {31'd0, a < b};
`endif
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called #1 after a posedge; returns #1 after the accepting edge.
   task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("busy_after_start", {31'd0, bus.busy}, 32'd1);
   endtask

   // Waits for done, counting edges since the accepting edge (elapsed already spent).
   task automatic wait_done(input string tag, input int elapsed, input logic [31:0] exp);
      int  n;
      bit  hold_ok;
      hold_ok = 1'b1;
      n = elapsed;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (bus.done) break;
         if (bus.d !== last_d) hold_ok = 1'b0;
      end
      check({tag, "_latency"}, n, 32);
      check({tag, "_dhold"}, {31'd0, hold_ok}, 32'd1);
      check({tag, "_d"}, bus.d, exp);
      check({tag, "_busy_lo"}, {31'd0, bus.busy}, 32'd0);
      last_d = bus.d;
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      launch(op, a, b);
      wait_done(tag, 0, exp);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
   endtask

   initial begin
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      logic [3:0]  ops [12];
      bit          saw_done;
      ops = '{4'b0000, 4'b1000, 4'b0100, 4'b0110, 4'b0111, 4'b1100,
              4'b0010, 4'b0011, 4'b1010, 4'b1011, 4'b0001, 4'b0101};

      rstn = 1'b0; bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
      last_d = 32'd0;
      #12;
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_d", bus.d, 32'd0);
      @(posedge clk); #1; rstn = 1'b1;
      @(posedge clk); #1;

      run_op("add", 4'b0000, 32'd5, 32'd3, 32'h0000_0008);
      run_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
      run_op("sub", 4'b1000, 32'd3, 32'd5, 32'hFFFF_FFFE);
      run_op("sub_min", 4'b1000, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF);
`ifdef NANOV_ALU_CMP_EN
      run_op("slt_neg", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1);
      run_op("sltu_big", 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0);
      run_op("sltu_small", 4'b0011, 32'd1, 32'd2, 32'd1);
      run_op("slt_maxmin", 4'b0010, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0);
`else
      run_op("slt_off", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0);
      run_op("sltu_off", 4'b0011, 32'd1, 32'd2, 32'd0);
`endif
      for (int k = 0; k < 2; k++) begin
         run_op("xor", {k[0], 3'b100}, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
         run_op("or",  {k[0], 3'b110}, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
         run_op("and", {k[0], 3'b111}, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
      end

      // Start pulsed mid-operation must be ignored.
      launch(4'b0000, 32'd100, 32'd23);
      repeat (9) begin @(posedge clk); #1; end
      bus.start = 1'b1; bus.op = 4'b1000; bus.a = 32'd5; bus.b = 32'd1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done("ignore_start", 10, 32'd123);
      repeat (3) begin @(posedge clk); #1; end
      check("ignore_idle", {30'd0, bus.busy, bus.done}, 32'd0);

      // Back-to-back: new start issued while done is high.
      launch(4'b0000, 32'd1000, 32'd234);
      wait_done("b2b_first", 0, 32'd1234);
      launch(4'b1000, 32'd10, 32'd4);
      wait_done("b2b_second", 0, 32'd6);

      // Reset at cycle 15 of an operation.
      launch(4'b0000, 32'h1234_5678, 32'h1111_1111);
      repeat (15) begin @(posedge clk); #1; end
      rstn = 1'b0; #1;
      check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      check("mid_rst_done", {31'd0, bus.done}, 32'd0);
      check("mid_rst_d", bus.d, 32'd0);
      @(posedge clk); #1; rstn = 1'b1;
      last_d = 32'd0;
      saw_done = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (bus.done || bus.busy) saw_done = 1'b1; end
      check("mid_rst_no_done", {31'd0, saw_done}, 32'd0);
      run_op("after_rst_add", 4'b0000, 32'd7, 32'd9, 32'h0000_0010);

      // Randomized back-to-back operations against the word-level model.
      for (int i = 0; i < 40; i++) begin
         rop = ops[$urandom_range(0, 11)];
         ra  = $urandom;
         rb  = $urandom;
         if (i % 4 == 0) rb = ra ^ (32'h1 << $urandom_range(0, 31));
         if (i % 7 == 0) ra = {ra[31], 31'd0};
         launch(rop, ra, rb);
         wait_done($sformatf("rnd%0d_op%h", i, rop), 0, model(rop, ra, rb));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
